// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built on one 4-bit ripple slice, one nibble per clock, LSB first.
// Optional subtract mode is enabled by defining NSA_SUB_EN, which adds the sub port.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | adding nibble idx with the registered carry
    // DONE  | result held until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [4:0]      slice;
    logic            msb_cin;

    // Constant-index mux keeps the nibble select free of variable part-selects.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IW'(k)) begin
                nib_a = a_r[4*k +: 4];
                nib_b = b_r[4*k +: 4];
            end
        end
        slice   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        msb_cin = nib_a[3] ^ nib_b[3] ^ slice[3];
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        idx   <= '0;
                        state <= RUN;
`ifdef NSA_SUB_EN
                        if (sub) begin
                            b_r   <= ~b;
                            carry <= 1'b1;
                        end else begin
                            b_r   <= b;
                            carry <= cin;
                        end
`else
                        b_r   <= b;
                        carry <= cin;
`endif
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (idx == IW'(k)) sum[4*k +: 4] <= slice[3:0];
                    end
                    carry <= slice[4];
                    if (idx == LAST) begin
                        cout      <= slice[4];
                        ovf       <= slice[4] ^ msb_cin;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: behavioural model plus directed literal cases.
// Define NSA_SUB_EN for both files to exercise subtract mode.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
`ifdef NSA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef NSA_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic ci, input logic s);
        logic [WIDTH-1:0] yy;
        logic             c0;
        logic [WIDTH:0]   full;
        logic             o;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
        o    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {o, full};
    endfunction

    // Behavioural model: busy for NIB cycles after an accept, then holds the result.
    logic             started = 1'b0;
    logic             bb_mode = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_outv = 1'b0;
    int               m_cnt = 0;
    int               cycle = 0;
    int               last_acc = -1;
    logic [WIDTH+1:0] pend = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;

    always @(posedge clk) begin
        cycle++;
        started = 1'b1;
        if (!bb_mode) last_acc = -1;
        if (rst) begin
            m_busy = 1'b0; m_outv = 1'b0; m_cnt = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_outv) begin
            if (out_ready) m_outv = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == NIB) begin
                m_busy = 1'b0;
                m_outv = 1'b1;
                {m_ovf, m_cout, m_sum} = pend;
            end
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            pend   = ref_add(a, b, cin, SUB_EN && sub);
            if (bb_mode && last_acc >= 0) chk("accept_gap", cycle - last_acc, NIB + 2);
            last_acc = cycle;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, m_outv);
            chk("in_ready", in_ready, !rst && !m_busy && !m_outv);
            if (!m_busy) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
                chk("ovf", ovf, m_ovf);
            end
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic s);
        int n;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_handshake", in_ready, 1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                         input logic s, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        start_op(x, y, ci, s);
        wait_result(lat);
        chk("latency", lat, NIB);
        chk("lit_sum", sum, es);
        chk("lit_cout", cout, ec);
        chk("lit_ovf", ovf, eo);
        release_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef NSA_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Backpressure: result must hold while new operands are offered.
        start_op(16'hA5A5, 16'h1111, 1'b1, 1'b0);
        wait_result(lat);
        chk("bp_latency", lat, NIB);
        in_valid = 1'b1;
        repeat (5) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(posedge clk); #1;
            chk("bp_sum", sum, 16'hB6B7);
            chk("bp_cout", cout, 0);
            chk("bp_ovf", ovf, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_result();
        chk("bp_out_valid_dropped", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_no_capture", in_ready, 1);

        // Reset after two nibbles have been written.
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_sum", sum, 0);
        chk("midrun_in_ready_in_reset", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        // Back-to-back with both handshakes held open.
        bb_mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (40) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bb_mode = 1'b0;

        // Randomized traffic with stalls and occasional resets.
        repeat (800) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
